// File: rtl/uart_pkg.sv
// uart_pkg: types and defaults shared by uart_fifo_core and uart_sync_fifo.
//   - uart_state_e : FSM states used by both the TX and RX machines
//   - DEF_*        : default parameter values
//   - ptr_w()      : FIFO pointer width (address bits + 1 wrap bit)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int DEF_NB_DATA      = 8;
  localparam int DEF_FIFO_DEPTH   = 16;
  localparam int DEF_OVERSAMPLING = 16;
  localparam int DEF_NB_DIV       = 16;

  // The extra MSB tells a full FIFO apart from an empty one when the
  // address bits of the two pointers are equal.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with a registered storage array.
// Ports:
//   clk, i_rst_n  clock, async active-low reset (contents cleared to 0)
//   i_push/i_data write request and data (dropped when full and no pop)
//   i_pop         read request (ignored when empty)
//   o_data        current head entry, read from registered storage
//   o_full/o_empty status from the pointer MSB compare
// FIFO_DEPTH must be a power of two, >= 2.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int NB_DATA    = DEF_NB_DATA,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_pop,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_full,
  output logic               o_empty
);

  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]                      wr_q, wr_d, rd_q, rd_d;
  logic [FIFO_DEPTH-1:0][NB_DATA-1:0] mem_q, mem_d;
  logic                               wr_en, rd_en;

  assign o_empty = (wr_q == rd_q);
  assign o_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign o_data  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    // Empty is judged before this cycle's push, so a push into an empty
    // FIFO cannot be popped in the same cycle. A pop frees a full slot in
    // the same cycle, so push+pop on full both proceed.
    rd_en = i_pop && !o_empty;
    wr_en = i_push && (!o_full || rd_en);
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_q[AW-1:0]] = i_data;
      wr_d                = wr_q + 1'b1;
    end
    if (rd_en) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: buffered UART with runtime baud divisor.
// Ports:
//   clk, i_rst_n                     clock, async active-low reset
//   i_baud_div                       tick period - 1 (clk cycles)
//   i_rx / o_tx                      serial lines, idle high
//   i_tx_data/i_tx_valid/o_tx_ready  TX FIFO push handshake
//   o_rx_data/o_rx_valid/i_rx_ready  RX FIFO pop handshake
//   o_tx_busy                        TX FIFO non-empty or frame in flight
//   o_rx_overrun/o_frame_err/o_parity_err  sticky errors
//   i_clear_err                      clears the sticky errors (set wins)
// Build option: define UART_FIFO_PARITY_EN for an even-parity bit in both
// directions; otherwise frames are 8N1 and o_parity_err is 0.
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int NB_DATA      = DEF_NB_DATA,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int NB_DIV       = DEF_NB_DIV,
  parameter int OVERSAMPLING = DEF_OVERSAMPLING
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_DIV-1:0]  i_baud_div,
  input  logic               i_rx,
  output logic               o_tx,
  input  logic [NB_DATA-1:0] i_tx_data,
  input  logic               i_tx_valid,
  output logic               o_tx_ready,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_valid,
  input  logic               i_rx_ready,
  output logic               o_tx_busy,
  output logic               o_rx_overrun,
  output logic               o_frame_err,
  output logic               o_parity_err,
  input  logic               i_clear_err
);

  localparam int OSW = (OVERSAMPLING > 2) ? $clog2(OVERSAMPLING) : 1;
  localparam int BW  = $clog2(NB_DATA);
  localparam logic [OSW-1:0] OS_LAST   = OSW'(OVERSAMPLING - 1);
  localparam logic [OSW-1:0] HALF_LAST = OSW'(OVERSAMPLING / 2 - 1);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(NB_DATA - 1);
`ifdef UART_FIFO_PARITY_EN
  localparam uart_state_e ST_AFTER_DATA = ST_PARITY;
`else
  localparam uart_state_e ST_AFTER_DATA = ST_STOP;
`endif

  // ---------------- tick generator ----------------
  logic [NB_DIV-1:0] cnt_q, cnt_d, div_q, div_d, div_eff;
  logic              tick;

  always_comb begin
    // The divisor is captured while the counter sits at 0, so a change
    // only takes effect after the current period wraps.
    div_eff = (cnt_q == '0) ? i_baud_div : div_q;
    tick    = (cnt_q == div_eff);
    div_d   = div_eff;
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
  end

  // ---------------- FIFOs ----------------
  logic               tx_full, tx_empty, tx_pop;
  logic [NB_DATA-1:0] tx_head;
  logic               rx_full, rx_empty, rx_push, rx_drop;
  logic [NB_DATA-1:0] rx_sh_q, rx_sh_d;

  assign o_tx_ready = !tx_full;
  assign o_rx_valid = !rx_empty;
  // A full RX FIFO still accepts the byte when a pop frees a slot.
  assign rx_drop    = rx_push && rx_full && !i_rx_ready;

  uart_sync_fifo #(.NB_DATA(NB_DATA), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .i_rst_n(i_rst_n),
    .i_push(i_tx_valid && !tx_full), .i_data(i_tx_data),
    .i_pop(tx_pop), .o_data(tx_head),
    .o_full(tx_full), .o_empty(tx_empty)
  );

  uart_sync_fifo #(.NB_DATA(NB_DATA), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .i_rst_n(i_rst_n),
    .i_push(rx_push), .i_data(rx_sh_q),
    .i_pop(i_rx_ready), .o_data(o_rx_data),
    .o_full(rx_full), .o_empty(rx_empty)
  );

  // ---------------- TX FSM ----------------
  uart_state_e        tx_state_q, tx_state_d;
  logic [OSW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]      tx_bit_q, tx_bit_d;
  logic [NB_DATA-1:0] tx_sh_q, tx_sh_d;
  logic               tx_q, tx_d, tx_load, tx_bit_end;
`ifdef UART_FIFO_PARITY_EN
  logic               tx_par_q, tx_par_d;
`endif

  assign tx_bit_end = tick && (tx_cnt_q == OS_LAST);
  assign o_tx       = tx_q;
  assign o_tx_busy  = !tx_empty || (tx_state_q != ST_IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_load    = 1'b0;
    if (tx_state_q != ST_IDLE && tick)
      tx_cnt_d = (tx_cnt_q == OS_LAST) ? '0 : tx_cnt_q + 1'b1;
    unique case (tx_state_q)
      ST_IDLE:  tx_load = tick && !tx_empty;
      ST_START: if (tx_bit_end) begin
        tx_bit_d   = '0;
        tx_state_d = ST_DATA;
      end
      ST_DATA:  if (tx_bit_end) begin
        tx_sh_d = tx_sh_q >> 1;
        if (tx_bit_q == BIT_LAST) tx_state_d = ST_AFTER_DATA;
        else                      tx_bit_d   = tx_bit_q + 1'b1;
      end
`ifdef UART_FIFO_PARITY_EN
      ST_PARITY: if (tx_bit_end) tx_state_d = ST_STOP;
`endif
      ST_STOP:  if (tx_bit_end) begin
        // Chain straight into the next frame when data is waiting.
        tx_load    = !tx_empty;
        tx_state_d = ST_IDLE;
      end
      default:  tx_state_d = ST_IDLE;
    endcase
    if (tx_load) begin
      tx_sh_d    = tx_head;
      tx_cnt_d   = '0;
      tx_state_d = ST_START;
    end
    tx_pop = tx_load;
`ifdef UART_FIFO_PARITY_EN
    tx_par_d = tx_load ? ^tx_head : tx_par_q;
`endif
    // Line level is registered from the next state so o_tx is glitch-free.
    case (tx_state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = tx_sh_d[0];
`ifdef UART_FIFO_PARITY_EN
      ST_PARITY: tx_d = tx_par_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // ---------------- RX FSM ----------------
  uart_state_e    rx_state_q, rx_state_d;
  logic [OSW-1:0] rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]  rx_bit_q, rx_bit_d;
  logic           rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic           rx_fall, rx_bit_end, ferr_set;
  logic           ovr_q, ovr_d, ferr_q, ferr_d;
`ifdef UART_FIFO_PARITY_EN
  logic           perr_q, perr_d, perr_set;
`endif

  assign rx_fall    = rx_prev_q && !rx_s2_q;
  assign rx_bit_end = tick && (rx_cnt_q == OS_LAST);

  always_comb begin
    rx_s1_d    = i_rx;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
`ifdef UART_FIFO_PARITY_EN
    perr_set   = 1'b0;
`endif
    if (rx_state_q != ST_IDLE && tick)
      rx_cnt_d = (rx_cnt_q == OS_LAST) ? '0 : rx_cnt_q + 1'b1;
    unique case (rx_state_q)
      ST_IDLE:  if (rx_fall) begin
        rx_cnt_d   = '0;
        rx_state_d = ST_START;
      end
      // Half a bit in: re-check the start bit, and from here on every
      // sample lands mid-bit.
      ST_START: if (tick && rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
      end
      ST_DATA:  if (rx_bit_end) begin
        rx_sh_d = {rx_s2_q, rx_sh_q[NB_DATA-1:1]};
        if (rx_bit_q == BIT_LAST) rx_state_d = ST_AFTER_DATA;
        else                      rx_bit_d   = rx_bit_q + 1'b1;
      end
`ifdef UART_FIFO_PARITY_EN
      ST_PARITY: if (rx_bit_end) begin
        perr_set   = (rx_s2_q != ^rx_sh_q);
        rx_state_d = ST_STOP;
      end
`endif
      ST_STOP:  if (rx_bit_end) begin
        rx_push    = 1'b1;
        ferr_set   = !rx_s2_q;
        rx_state_d = ST_IDLE;
      end
      default:  rx_state_d = ST_IDLE;
    endcase
    ovr_d  = rx_drop  || (ovr_q  && !i_clear_err);
    ferr_d = ferr_set || (ferr_q && !i_clear_err);
`ifdef UART_FIFO_PARITY_EN
    perr_d = perr_set || (perr_q && !i_clear_err);
`endif
  end

  assign o_rx_overrun = ovr_q;
  assign o_frame_err  = ferr_q;
`ifdef UART_FIFO_PARITY_EN
  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

  // ---------------- state registers ----------------
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q      <= '0;
      div_q      <= '0;
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

`ifdef UART_FIFO_PARITY_EN
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_par_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      tx_par_q <= tx_par_d;
      perr_q   <= perr_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: RX frame vector table plus hand
// sequences for glitch, loopback, overrun, TX-full, parity and reset.
module tb_uart_fifo_core;

  localparam int DIV = 3;
  localparam int OS  = 16;
  localparam int BIT = OS * (DIV + 1);
`ifdef UART_FIFO_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BIT;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [15:0] i_baud_div = 16'(DIV);
  logic        i_rx, o_tx;
  logic [7:0]  i_tx_data = '0;
  logic        i_tx_valid = 1'b0, o_tx_ready;
  logic [7:0]  o_rx_data;
  logic        o_rx_valid, i_rx_ready = 1'b0;
  logic        o_tx_busy, o_rx_overrun, o_frame_err, o_parity_err;
  logic        i_clear_err = 1'b0;
  logic        lb = 1'b0, rx_drv = 1'b1;
`ifdef UART_FIFO_PARITY_EN
  logic        rx_par_flip = 1'b0;
  logic        last_par;
`endif

  int n_checks = 0, n_fail = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign i_rx = lb ? o_tx : rx_drv;

  uart_fifo_core dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_baud_div(i_baud_div),
    .i_rx(i_rx), .o_tx(o_tx),
    .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
    .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready),
    .o_tx_busy(o_tx_busy), .o_rx_overrun(o_rx_overrun),
    .o_frame_err(o_frame_err), .o_parity_err(o_parity_err),
    .i_clear_err(i_clear_err)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       stop;
    logic       exp_ferr;
  } rx_vec_t;
  rx_vec_t rx_vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_tx"},       o_tx, 1);
    check({p, "_tx_ready"}, o_tx_ready, 1);
    check({p, "_rx_valid"}, o_rx_valid, 0);
    check({p, "_rx_data"},  o_rx_data, 0);
    check({p, "_busy"},     o_tx_busy, 0);
    check({p, "_ovr"},      o_rx_overrun, 0);
    check({p, "_ferr"},     o_frame_err, 0);
    check({p, "_perr"},     o_parity_err, 0);
  endtask

  task automatic push_tx(input logic [7:0] d);
    i_tx_data  = d;
    i_tx_valid = 1'b1;
    @(negedge clk);
    i_tx_valid = 1'b0;
  endtask

  task automatic pop_check(input string nm, input logic [7:0] exp);
    check({nm, "_valid"}, o_rx_valid, 1);
    check({nm, "_data"},  o_rx_data, 32'(exp));
    i_rx_ready = 1'b1;
    @(negedge clk);
    i_rx_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    i_clear_err = 1'b1;
    @(negedge clk);
    i_clear_err = 1'b0;
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic stop);
    rx_drv = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_FIFO_PARITY_EN
    rx_drv = (^d) ^ rx_par_flip;
    repeat (BIT) @(negedge clk);
`endif
    rx_drv = stop;
    repeat (BIT) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  // Decode one frame from o_tx by sampling at mid-bit; ok=0 on timeout or
  // a bad start/stop (or parity) bit.
  task automatic tx_capture(input int tmo, output logic [7:0] b, output logic ok);
    int t = 0;
    ok = 1'b0;
    b  = '0;
    while (o_tx !== 1'b0 && t < tmo) begin
      @(negedge clk);
      t++;
    end
    if (o_tx !== 1'b0) return;
    repeat (BIT / 2) @(negedge clk);
    if (o_tx !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(negedge clk);
      b[i] = o_tx;
    end
`ifdef UART_FIFO_PARITY_EN
    repeat (BIT) @(negedge clk);
    last_par = o_tx;
    if (last_par !== ^b) return;
`endif
    repeat (BIT) @(negedge clk);
    ok = (o_tx === 1'b1);
  endtask

  initial begin
    logic [7:0] b, exp_q[16];
    logic       ok;
    int         c0, t, lows;

    rx_vecs[0] = '{data: 8'h55, stop: 1'b0, exp_ferr: 1'b1};
    rx_vecs[1] = '{data: 8'h55, stop: 1'b1, exp_ferr: 1'b0};
    rx_vecs[2] = '{data: 8'hA5, stop: 1'b1, exp_ferr: 1'b0};
    rx_vecs[3] = '{data: 8'h00, stop: 1'b1, exp_ferr: 1'b0};
    rx_vecs[4] = '{data: 8'hFF, stop: 1'b0, exp_ferr: 1'b1};
    rx_vecs[5] = '{data: 8'h80, stop: 1'b1, exp_ferr: 1'b0};

    // Reset state
    do_reset();
    check_reset_vals("rst");

    // RX frame table
    for (int v = 0; v < 6; v++) begin
      pulse_clear();
      drive_rx(rx_vecs[v].data, rx_vecs[v].stop);
      repeat (4) @(negedge clk);
      check($sformatf("rxv%0d_ferr", v), o_frame_err, 32'(rx_vecs[v].exp_ferr));
      check($sformatf("rxv%0d_ovr", v), o_rx_overrun, 0);
      pop_check($sformatf("rxv%0d", v), rx_vecs[v].data);
      check($sformatf("rxv%0d_empty", v), o_rx_valid, 0);
    end
    pulse_clear();
    check("ferr_cleared", o_frame_err, 0);

    // Glitch: low for 5 ticks, shorter than the half-bit recheck
    rx_drv = 1'b0;
    repeat (5 * (DIV + 1)) @(negedge clk);
    rx_drv = 1'b1;
    repeat (FRAME) @(negedge clk);
    check("glitch_valid", o_rx_valid, 0);
    check("glitch_ferr", o_frame_err, 0);

    // Loopback, four back-to-back frames
    do_reset();
    lb = 1'b1;
    push_tx(8'hA5);
    c0 = cyc;
    push_tx(8'h3C);
    push_tx(8'hFF);
    push_tx(8'h00);
    check("lb_busy", o_tx_busy, 1);
    t = 0;
    while (o_tx_busy && t < 6 * FRAME) begin
      @(negedge clk);
      t++;
    end
    check("lb_busy_fall", o_tx_busy, 0);
    check("lb_busy_min", 32'(cyc - c0 >= 4 * FRAME + 1), 1);
    check("lb_busy_max", 32'(cyc - c0 <= 4 * FRAME + DIV + 1), 1);
    repeat (4) @(negedge clk);
    pop_check("lb0", 8'hA5);
    pop_check("lb1", 8'h3C);
    pop_check("lb2", 8'hFF);
    pop_check("lb3", 8'h00);
    check("lb_empty", o_rx_valid, 0);
    check("lb_ferr", o_frame_err, 0);
    check("lb_ovr", o_rx_overrun, 0);
    check("lb_perr", o_parity_err, 0);
    lb = 1'b0;

    // RX overrun: 17 frames, no pops
    for (int k = 1; k <= 17; k++) begin
      drive_rx(8'(k), 1'b1);
      if (k == 16) begin
        repeat (2) @(negedge clk);
        check("ovr_not_yet", o_rx_overrun, 0);
      end
    end
    repeat (4) @(negedge clk);
    check("ovr_set", o_rx_overrun, 1);
    for (int k = 1; k <= 16; k++) pop_check($sformatf("ovr%0d", k), 8'(k));
    check("ovr_drained", o_rx_valid, 0);
    pulse_clear();
    check("ovr_cleared", o_rx_overrun, 0);

    // TX full: slow first tick so 16 pushes fill the FIFO, then speed up
    i_baud_div = 16'd200;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      exp_q[k] = 8'(k * 37 + 5);
      push_tx(exp_q[k]);
    end
    check("txf_ready_low", o_tx_ready, 0);
    push_tx(8'hEE);
    check("txf_ready_still_low", o_tx_ready, 0);
    check("txf_busy", o_tx_busy, 1);
    i_baud_div = 16'(DIV);
    for (int k = 0; k < 16; k++) begin
      tx_capture(2000, b, ok);
      check($sformatf("txf%0d_ok", k), ok, 1);
      check($sformatf("txf%0d_data", k), b, 32'(exp_q[k]));
    end
    lows = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (o_tx === 1'b0) lows++;
    end
    check("txf_no_17th", lows, 0);
    check("txf_idle", o_tx_busy, 0);
    check("txf_ready_back", o_tx_ready, 1);

`ifdef UART_FIFO_PARITY_EN
    // Parity: TX 0x07 carries a 1; bad RX parity sets the flag
    do_reset();
    push_tx(8'h07);
    tx_capture(2000, b, ok);
    check("par_tx_ok", ok, 1);
    check("par_tx_bit", last_par, 1);
    rx_par_flip = 1'b1;
    drive_rx(8'h07, 1'b1);
    rx_par_flip = 1'b0;
    repeat (4) @(negedge clk);
    check("par_rx_err", o_parity_err, 1);
    pop_check("par_rx", 8'h07);
    pulse_clear();
    check("par_cleared", o_parity_err, 0);
`endif

    // Reset mid-frame
    do_reset();
    check("mid_busy_before", o_tx_busy, 0);
    push_tx(8'h00);
    check("mid_busy_latency", o_tx_busy, 1);
    t = 0;
    while (o_tx !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (BIT + BIT / 2) @(negedge clk);
    check("mid_tx_low", o_tx, 0);
    #2 i_rst_n = 1'b0;
    #1 check("mid_tx_async", o_tx, 1);
    @(negedge clk);
    check_reset_vals("mid");
    i_rst_n = 1'b1;
    @(negedge clk);
    push_tx(8'h5A);
    tx_capture(2000, b, ok);
    check("mid_after_ok", ok, 1);
    check("mid_after_data", b, 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
